// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its store controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, register/data widths, default store-ack wait
// limit, and a helper that sizes the store-ack wait counter.
package wb_pkg;

  localparam int REG_W            = 4;
  localparam int DATA_W           = 64;
  localparam int MAX_WAIT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    HALTED     = 2'd2
  } wbState_t;

  // The wait counter is never narrower than 8 bits. It grows only when the
  // limit does not fit in 8 bits.
  function automatic int waitCntWidth(input int maxWait);
    return (maxWait > 255) ? $clog2(maxWait + 1) : 8;
  endfunction

endpackage

// File: rtl/wb_store_ctrl.sv
// Store request holder: issues one store and holds it until ack or timeout.
// Latency: storeReq rises the cycle after start and drops the cycle after ack or expiry.
// Backpressure: request, address and data stay frozen while storeAck is low.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   start            load a new store (only pulsed while no store is pending)
//   addr, data       address and data captured on start
//   storeAck         memory accepted the store (ignored while storeReq is low)
//   storeReq/Addr/Data  held store request towards memory
//   storeDone        combinational: the pending store finishes at this edge
//   storeTimeoutErr  sticky; set when the wait limit expires without an ack
module wb_store_ctrl
  import wb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              storeAck,
  output logic              storeReq,
  output logic [DATA_W-1:0] storeAddr,
  output logic [DATA_W-1:0] storeData,
  output logic              storeDone,
  output logic              storeTimeoutErr
);

  localparam int               CNT_W    = waitCntWidth(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] waitCnt;
  logic             ackSeen;
  logic             expired;

  // An ack only counts while a request is actually outstanding. If the ack
  // arrives in the very cycle the limit runs out, the ack takes priority.
  assign ackSeen   = storeReq & storeAck;
  assign expired   = storeReq & ~storeAck & (waitCnt == LAST_CNT);
  assign storeDone = ackSeen | expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      storeReq        <= 1'b0;
      storeAddr       <= '0;
      storeData       <= '0;
      waitCnt         <= '0;
      storeTimeoutErr <= 1'b0;
    end else begin
      if (start) begin
        storeReq  <= 1'b1;
        storeAddr <= addr;
        storeData <= data;
        waitCnt   <= '0;
      end else if (storeDone) begin
        storeReq <= 1'b0;
        waitCnt  <= '0;
      end else if (storeReq) begin
        waitCnt <= waitCnt + 1'b1;
      end

      if (expired) begin
        storeTimeoutErr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires execute results to two register-file ports and issues stores.
// Latency: register writes, store request and retire count update appear one cycle after accept.
// Backpressure: wbStallOut is registered and is high while a store waits for its ack or after a halt.
//
// Ports:
//   clk, reset                        clock; asynchronous active-high reset
//   exValidIn                         execute result valid (sampled only in IDLE)
//   aluResultIn / aluResultSpecialIn  primary / secondary (MUL high) result
//   destRegIn(+Valid), destRegSpecialIn(+Valid)  destination registers
//   isMemoryAccessDestIn, memoryAddressDestIn    store request and address
//   killIn                            halt-class instruction
//   wbStallOut                        stall towards execute
//   regWr*/regWr2*                    register-file write ports A and B
//   storeReq/Addr/Data, storeAck      store handshake with memory
//   haltOut, storeTimeoutErr          sticky status flags
//   retiredCount                      retired-instruction counter (wraps)
// Optional macro WB_FORWARD_EN adds fwdValid/fwdReg/fwdData, a combinational
// copy of write port A for decode bypass.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValidIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] aluResultSpecialIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [REG_W-1:0]  destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [DATA_W-1:0] memoryAddressDestIn,
  input  logic              killIn,
  output logic              wbStallOut,
  output logic              regWrEn,
  output logic [REG_W-1:0]  regWrAddr,
  output logic [DATA_W-1:0] regWrData,
  output logic              regWr2En,
  output logic [REG_W-1:0]  regWr2Addr,
  output logic [DATA_W-1:0] regWr2Data,
  output logic              storeReq,
  output logic [DATA_W-1:0] storeAddr,
  output logic [DATA_W-1:0] storeData,
  input  logic              storeAck,
  output logic              haltOut,
  output logic              storeTimeoutErr,
`ifdef WB_FORWARD_EN
  output logic              fwdValid,
  output logic [REG_W-1:0]  fwdReg,
  output logic [DATA_W-1:0] fwdData,
`endif
  output logic [DATA_W-1:0] retiredCount
);

  wbState_t state;
  wbState_t stateNext;
  logic     accept;
  logic     storeStart;
  logic     storeDone;
  logic     killPending;
  logic     sameDest;

  // Input is taken only when idle. In STORE_WAIT and HALTED, execute is
  // stalled, so any valid it shows is stale and gets dropped.
  assign accept     = (state == IDLE) & exValidIn;
  assign storeStart = accept & isMemoryAccessDestIn;

  // Port A wins a same-register collision. Port B is suppressed only when
  // port A is really writing.
  assign sameDest = destRegValidIn & (destRegSpecialIn == destRegIn);

  wb_store_ctrl #(
    .MAX_WAIT(MAX_WAIT)
  ) uStoreCtrl (
    .clk            (clk),
    .reset          (reset),
    .start          (storeStart),
    .addr           (memoryAddressDestIn),
    .data           (aluResultIn),
    .storeAck       (storeAck),
    .storeReq       (storeReq),
    .storeAddr      (storeAddr),
    .storeData      (storeData),
    .storeDone      (storeDone),
    .storeTimeoutErr(storeTimeoutErr)
  );

  // A halt that comes with a store is deferred until the store finishes,
  // whether it finishes by ack or by timeout.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isMemoryAccessDestIn) begin
            stateNext = STORE_WAIT;
          end else if (killIn) begin
            stateNext = HALTED;
          end
        end
      end
      STORE_WAIT: begin
        if (storeDone) begin
          stateNext = killPending ? HALTED : IDLE;
        end
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      killPending  <= 1'b0;
      wbStallOut   <= 1'b0;
      haltOut      <= 1'b0;
      regWrEn      <= 1'b0;
      regWrAddr    <= '0;
      regWrData    <= '0;
      regWr2En     <= 1'b0;
      regWr2Addr   <= '0;
      regWr2Data   <= '0;
      retiredCount <= '0;
    end else begin
      state      <= stateNext;
      // The stall is registered from the next state, so it lines up exactly
      // with the state register.
      wbStallOut <= (stateNext != IDLE);
      if (stateNext == HALTED) begin
        haltOut <= 1'b1;
      end

      regWrEn  <= 1'b0;
      regWr2En <= 1'b0;

      if (accept) begin
        killPending  <= killIn & isMemoryAccessDestIn;
        regWrEn      <= destRegValidIn;
        regWrAddr    <= destRegIn;
        regWrData    <= aluResultIn;
        regWr2En     <= destRegSpecialValidIn & ~sameDest;
        regWr2Addr   <= destRegSpecialIn;
        regWr2Data   <= aluResultSpecialIn;
        retiredCount <= retiredCount + 64'd1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdValid = regWrEn;
  assign fwdReg   = regWrAddr;
  assign fwdData  = regWrData;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage with directed scenarios and a randomized retire/store mix.
// Latency: checks are sampled on the falling edge, one cycle after each accept.
// Backpressure: store acks are delayed or withheld to exercise the hold and timeout paths.
module tb_writeback_stage;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        exValidIn;
  logic [63:0] aluResultIn;
  logic [63:0] aluResultSpecialIn;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic        isMemoryAccessDestIn;
  logic [63:0] memoryAddressDestIn;
  logic        killIn;
  logic        wbStallOut;
  logic        regWrEn;
  logic [3:0]  regWrAddr;
  logic [63:0] regWrData;
  logic        regWr2En;
  logic [3:0]  regWr2Addr;
  logic [63:0] regWr2Data;
  logic        storeReq;
  logic [63:0] storeAddr;
  logic [63:0] storeData;
  logic        storeAck;
  logic        haltOut;
  logic        storeTimeoutErr;
  logic [63:0] retiredCount;
`ifdef WB_FORWARD_EN
  logic        fwdValid;
  logic [3:0]  fwdReg;
  logic [63:0] fwdData;
`endif

  int          nChecks = 0;
  int          nFail   = 0;
  logic [63:0] expRetired;
  logic        expTimeout;

  always #5 clk = ~clk;

  writeback_stage #(.MAX_WAIT(MW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .exValidIn            (exValidIn),
    .aluResultIn          (aluResultIn),
    .aluResultSpecialIn   (aluResultSpecialIn),
    .destRegIn            (destRegIn),
    .destRegValidIn       (destRegValidIn),
    .destRegSpecialIn     (destRegSpecialIn),
    .destRegSpecialValidIn(destRegSpecialValidIn),
    .isMemoryAccessDestIn (isMemoryAccessDestIn),
    .memoryAddressDestIn  (memoryAddressDestIn),
    .killIn               (killIn),
    .wbStallOut           (wbStallOut),
    .regWrEn              (regWrEn),
    .regWrAddr            (regWrAddr),
    .regWrData            (regWrData),
    .regWr2En             (regWr2En),
    .regWr2Addr           (regWr2Addr),
    .regWr2Data           (regWr2Data),
    .storeReq             (storeReq),
    .storeAddr            (storeAddr),
    .storeData            (storeData),
    .storeAck             (storeAck),
    .haltOut              (haltOut),
    .storeTimeoutErr      (storeTimeoutErr),
`ifdef WB_FORWARD_EN
    .fwdValid             (fwdValid),
    .fwdReg               (fwdReg),
    .fwdData              (fwdData),
`endif
    .retiredCount         (retiredCount)
  );

  // Drive one instruction for one cycle. On return, the bench sits at the
  // falling edge where the accept+1 outputs are visible.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] d, input logic dv,
                       input logic [3:0] ds, input logic dsv, input logic st, input logic [63:0] addr,
                       input logic kill);
    exValidIn = 1'b1; aluResultIn = a; aluResultSpecialIn = b;
    destRegIn = d; destRegValidIn = dv; destRegSpecialIn = ds; destRegSpecialValidIn = dsv;
    isMemoryAccessDestIn = st; memoryAddressDestIn = addr; killIn = kill;
    @(negedge clk);
    exValidIn = 1'b0; isMemoryAccessDestIn = 1'b0; killIn = 1'b0;
    destRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1; exValidIn = 1'b0; storeAck = 1'b0; killIn = 1'b0; isMemoryAccessDestIn = 1'b0;
    destRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expRetired = '0; expTimeout = 1'b0;
  endtask

  task automatic test_reset();
    aluResultIn = '0; aluResultSpecialIn = '0; destRegIn = '0; destRegSpecialIn = '0; memoryAddressDestIn = '0;
    reset = 1'b1; exValidIn = 1'b0; storeAck = 1'b0; killIn = 1'b0; isMemoryAccessDestIn = 1'b0;
    destRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({regWrEn, regWr2En, storeReq, wbStallOut, haltOut, storeTimeoutErr} !== 6'b0) begin
      nFail++; $display("FAIL reset_flags: got %b expected 000000", {regWrEn, regWr2En, storeReq, wbStallOut, haltOut, storeTimeoutErr});
    end
    nChecks++;
    if (retiredCount !== 64'd0) begin nFail++; $display("FAIL reset_count: got %h expected 0", retiredCount); end
    nChecks++;
    if ({regWrData, regWr2Data, storeAddr, storeData, regWrAddr, regWr2Addr} !== '0) begin
      nFail++; $display("FAIL reset_data: got %h %h %h %h expected all 0", regWrData, regWr2Data, storeAddr, storeData);
    end
    reset = 1'b0;
    @(negedge clk);
    expRetired = '0; expTimeout = 1'b0;
  endtask

  task automatic test_add();
    issue(64'h5, 64'h0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 64'h0, 1'b0);
    expRetired++;
    nChecks++;
    if ({regWrEn, regWrAddr, regWrData} !== {1'b1, 4'd3, 64'h5}) begin
      nFail++; $display("FAIL add_portA: got en=%b addr=%0d data=%h expected en=1 addr=3 data=5", regWrEn, regWrAddr, regWrData);
    end
    nChecks++;
    if (regWr2En !== 1'b0) begin nFail++; $display("FAIL add_portB: got %b expected 0", regWr2En); end
    nChecks++;
    if (retiredCount !== 64'd1) begin nFail++; $display("FAIL add_count: got %0d expected 1", retiredCount); end
    @(negedge clk);
    nChecks++;
    if (regWrEn !== 1'b0) begin nFail++; $display("FAIL add_pulse: got %b expected 0", regWrEn); end
  endtask

  task automatic test_mul();
    issue(64'h10, 64'h1, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 64'h0, 1'b0);
    expRetired++;
    nChecks++;
    if ({regWrEn, regWrAddr, regWrData, regWr2En, regWr2Addr, regWr2Data} !== {1'b1, 4'd0, 64'h10, 1'b1, 4'd2, 64'h1}) begin
      nFail++; $display("FAIL mul_both: got A=%b/%0d/%h B=%b/%0d/%h expected A=1/0/10 B=1/2/1",
                        regWrEn, regWrAddr, regWrData, regWr2En, regWr2Addr, regWr2Data);
    end
    issue(64'h22, 64'h33, 4'd6, 1'b1, 4'd6, 1'b1, 1'b0, 64'h0, 1'b0);
    expRetired++;
    nChecks++;
    if ({regWrEn, regWrData, regWr2En} !== {1'b1, 64'h22, 1'b0}) begin
      nFail++; $display("FAIL mul_same: got A=%b/%h B=%b expected A=1/22 B=0", regWrEn, regWrData, regWr2En);
    end
    issue(64'h44, 64'h55, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 64'h0, 1'b0);
    expRetired++;
    nChecks++;
    if ({regWrEn, regWr2En, regWr2Addr, regWr2Data} !== {1'b0, 1'b1, 4'd5, 64'h55}) begin
      nFail++; $display("FAIL mul_bonly: got A=%b B=%b/%0d/%h expected A=0 B=1/5/55", regWrEn, regWr2En, regWr2Addr, regWr2Data);
    end
    nChecks++;
    if (retiredCount !== expRetired) begin nFail++; $display("FAIL mul_count: got %0d expected %0d", retiredCount, expRetired); end
    @(negedge clk);
  endtask

  task automatic test_store_ack();
    issue(64'hAB, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 64'h1000, 1'b0);
    expRetired++;
    for (int k = 1; k <= 3; k++) begin
      nChecks++;
      if ({storeReq, wbStallOut, storeAddr, storeData} !== {1'b1, 1'b1, 64'h1000, 64'hAB}) begin
        nFail++; $display("FAIL store_hold[%0d]: got req=%b stall=%b addr=%h data=%h expected 1 1 1000 ab",
                          k, storeReq, wbStallOut, storeAddr, storeData);
      end
      storeAck = (k == 3);
      @(negedge clk);
    end
    storeAck = 1'b0;
    nChecks++;
    if ({storeReq, wbStallOut, storeTimeoutErr} !== 3'b000) begin
      nFail++; $display("FAIL store_done: got req=%b stall=%b tmo=%b expected 000", storeReq, wbStallOut, storeTimeoutErr);
    end
    issue(64'h9, 64'h0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 64'h0, 1'b0);
    expRetired++;
    nChecks++;
    if ({regWrEn, retiredCount} !== {1'b1, expRetired}) begin
      nFail++; $display("FAIL store_idle: got en=%b count=%0d expected en=1 count=%0d", regWrEn, retiredCount, expRetired);
    end
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    storeAck = 1'b1;
    repeat (2) @(negedge clk);
    issue(64'hCD, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 64'h2000, 1'b0);
    expRetired++;
    storeAck = 1'b0;
    @(negedge clk);
    nChecks++;
    if (storeReq !== 1'b1) begin nFail++; $display("FAIL stray_ack: got req=%b expected 1", storeReq); end
    storeAck = 1'b1;
    @(negedge clk);
    storeAck = 1'b0;
    nChecks++;
    if (storeReq !== 1'b0) begin nFail++; $display("FAIL stray_ack_end: got req=%b expected 0", storeReq); end
  endtask

  task automatic test_timeout();
    issue(64'hEE, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 64'h3000, 1'b0);
    expRetired++;
    for (int k = 1; k <= MW; k++) begin
      nChecks++;
      if ({storeReq, wbStallOut, storeTimeoutErr} !== 3'b110) begin
        nFail++; $display("FAIL tmo_wait[%0d]: got req=%b stall=%b tmo=%b expected 110", k, storeReq, wbStallOut, storeTimeoutErr);
      end
      @(negedge clk);
    end
    expTimeout = 1'b1;
    nChecks++;
    if ({storeReq, wbStallOut, storeTimeoutErr} !== 3'b001) begin
      nFail++; $display("FAIL tmo_end: got req=%b stall=%b tmo=%b expected 001", storeReq, wbStallOut, storeTimeoutErr);
    end
  endtask

  // Reference model: port A writes whenever its destination is valid. Port B
  // writes unless port A targets the same register. A store stays requested
  // for min(ackDelay, MW) cycles, and it times out when the ack would come later.
  task automatic test_random();
    logic [63:0] a, b, addr;
    logic [3:0]  d, ds;
    logic        dv, dsv, st, expB;
    int          ackDelay, reqCycles;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; addr = {$urandom, $urandom};
      d = 4'($urandom_range(0, 15)); ds = ($urandom_range(0, 2) == 0) ? d : 4'($urandom_range(0, 15));
      dv = 1'($urandom); dsv = 1'($urandom); st = ($urandom_range(0, 2) == 0);
      ackDelay = $urandom_range(1, MW + 2);
      reqCycles = (ackDelay < MW) ? ackDelay : MW;
      expB = dsv && !(dv && (ds == d));
      issue(a, b, d, dv, ds, dsv, st, addr, 1'b0);
      expRetired++;
      nChecks++;
      if ({regWrEn, regWr2En, storeReq, wbStallOut} !== {dv, expB, st, st}) begin
        nFail++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b expected %b%b%b%b", n, regWrEn, regWr2En, storeReq, wbStallOut, dv, expB, st, st);
      end
      nChecks++;
      if ((dv && {regWrAddr, regWrData} !== {d, a}) || (expB && {regWr2Addr, regWr2Data} !== {ds, b})) begin
        nFail++; $display("FAIL rnd_data[%0d]: got A=%0d/%h B=%0d/%h expected A=%0d/%h B=%0d/%h",
                          n, regWrAddr, regWrData, regWr2Addr, regWr2Data, d, a, ds, b);
      end
      nChecks++;
      if (retiredCount !== expRetired) begin nFail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, retiredCount, expRetired); end
      if (st) begin
        for (int k = 1; k <= reqCycles; k++) begin
          if (k > 1) begin
            nChecks++;
            if ({storeReq, wbStallOut, regWrEn, regWr2En, storeAddr, storeData} !== {4'b1100, addr, a}) begin
              nFail++; $display("FAIL rnd_hold[%0d.%0d]: got req=%b stall=%b wr=%b%b addr=%h data=%h expected 1 1 00 %h %h",
                                n, k, storeReq, wbStallOut, regWrEn, regWr2En, storeAddr, storeData, addr, a);
            end
          end
          storeAck = (k == ackDelay);
          exValidIn = 1'($urandom); destRegValidIn = 1'b1; destRegSpecialValidIn = 1'b1;
          @(negedge clk);
        end
        storeAck = 1'b0; exValidIn = 1'b0; destRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0;
        if (ackDelay > MW) expTimeout = 1'b1;
        nChecks++;
        if ({storeReq, wbStallOut, storeTimeoutErr, retiredCount} !== {1'b0, 1'b0, expTimeout, expRetired}) begin
          nFail++; $display("FAIL rnd_end[%0d]: got req=%b stall=%b tmo=%b count=%0d expected 0 0 %b %0d",
                            n, storeReq, wbStallOut, storeTimeoutErr, retiredCount, expTimeout, expRetired);
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_kill();
    issue(64'h77, 64'h0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 64'h0, 1'b1);
    expRetired++;
    nChecks++;
    if ({regWrEn, haltOut, wbStallOut, retiredCount} !== {3'b111, expRetired}) begin
      nFail++; $display("FAIL kill_enter: got en=%b halt=%b stall=%b count=%0d expected 1 1 1 %0d",
                        regWrEn, haltOut, wbStallOut, retiredCount, expRetired);
    end
    for (int k = 0; k < 5; k++) begin
      exValidIn = 1'b1; destRegValidIn = 1'b1; destRegSpecialValidIn = 1'b1; isMemoryAccessDestIn = 1'b1;
      @(negedge clk);
      nChecks++;
      if ({regWrEn, regWr2En, storeReq, haltOut, wbStallOut, retiredCount} !== {5'b00011, expRetired}) begin
        nFail++; $display("FAIL kill_hold[%0d]: got wr=%b%b req=%b halt=%b stall=%b count=%0d expected 00 0 1 1 %0d",
                          k, regWrEn, regWr2En, storeReq, haltOut, wbStallOut, retiredCount, expRetired);
      end
    end
    applyReset();
    nChecks++;
    if ({haltOut, wbStallOut} !== 2'b00) begin nFail++; $display("FAIL kill_reset: got halt=%b stall=%b expected 00", haltOut, wbStallOut); end
    issue(64'h88, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 64'h4000, 1'b1);
    nChecks++;
    if (storeReq !== 1'b1) begin nFail++; $display("FAIL killst_req: got %b expected 1", storeReq); end
    storeAck = 1'b1;
    @(negedge clk);
    storeAck = 1'b0;
    nChecks++;
    if ({storeReq, haltOut, wbStallOut} !== 3'b011) begin
      nFail++; $display("FAIL killst_halt: got req=%b halt=%b stall=%b expected 011", storeReq, haltOut, wbStallOut);
    end
    applyReset();
  endtask

  task automatic test_reset_in_store();
    issue(64'h99, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 64'h5000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    nChecks++;
    if ({storeReq, wbStallOut, retiredCount} !== {2'b00, 64'd0}) begin
      nFail++; $display("FAIL rst_store: got req=%b stall=%b count=%0d expected 0 0 0", storeReq, wbStallOut, retiredCount);
    end
    @(negedge clk);
    reset = 1'b0;
    expRetired = '0; expTimeout = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nChecks++;
      if ({storeReq, wbStallOut} !== 2'b00) begin
        nFail++; $display("FAIL rst_after[%0d]: got req=%b stall=%b expected 00", k, storeReq, wbStallOut);
      end
    end
  endtask

  task automatic test_wrap();
    force dut.retiredCount = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.retiredCount;
    issue(64'h1, 64'h0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 64'h0, 1'b0);
    nChecks++;
    if (retiredCount !== 64'd0) begin nFail++; $display("FAIL wrap: got %h expected 0", retiredCount); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_store_ack();
    test_stray_ack();
    test_timeout();
    test_random();
    test_kill();
    test_reset_in_store();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter MAX_WAIT, default 255: store-ack wait limit, in cycles, before timeout.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 exValidIn  in  1  execute result valid (isExecuteSuccessfulOut).
REQ-005 aluResultIn  in  64  primary result.
REQ-006 aluResultSpecialIn  in  64  secondary result (MUL high half).
REQ-007 destRegIn / destRegValidIn  in  4 / 1  primary destination register.
REQ-008 destRegSpecialIn / destRegSpecialValidIn  in  4 / 1  secondary destination register.
REQ-009 isMemoryAccessDestIn / memoryAddressDestIn  in  1 / 64  store request and address.
REQ-010 killIn  in  1  halt-class instruction retired.
REQ-011 wbStallOut  out  1  stall to execute.
REQ-012 regWrEn / regWrAddr / regWrData  out  1 / 4 / 64  register-file write port A.
REQ-013 regWr2En / regWr2Addr / regWr2Data  out  1 / 4 / 64  register-file write port B.
REQ-014 storeReq / storeAddr / storeData  out  1 / 64 / 64  store request to memory.
REQ-015 storeAck  in  1  memory accepted store.
REQ-016 haltOut / storeTimeoutErr  out  1 / 1  sticky halt; sticky store timeout.
REQ-017 retiredCount  out  64  retired-instruction counter.

Function
REQ-018 FSM states SHALL be IDLE, STORE_WAIT and HALTED.
REQ-019 Accept: in IDLE with exValidIn=1, the block SHALL capture all inputs; the value of exValidIn is ignored in any other state.
REQ-020 Port-A write: regWrEn SHALL pulse one cycle, in the cycle after accept, when destRegValidIn=1, with aluResultIn.
REQ-021 Port-B write: regWr2En SHALL pulse in the same cycle when destRegSpecialValidIn=1, with aluResultSpecialIn.
REQ-022 Equal addresses: if both ports target the same register, only port A SHALL write.
REQ-023 Store issue: on accept with isMemoryAccessDestIn=1, the FSM SHALL enter STORE_WAIT; storeReq SHALL assert the next cycle with storeData=aluResultIn.
REQ-024 storeReq, storeAddr and storeData SHALL hold stable until the cycle storeAck=1; the FSM SHALL then return to IDLE and storeReq SHALL drop the following cycle.
REQ-025 storeAck SHALL be honoured in the first cycle storeReq is high; storeAck while storeReq=0 SHALL be ignored.
REQ-026 A store with destRegValidIn=1 SHALL perform the register write at accept+1, independent of ack.
REQ-027 wbStallOut SHALL be registered and high in STORE_WAIT and HALTED, low in IDLE.
REQ-028 Timeout: an 8+ bit wait counter SHALL reach MAX_WAIT with no ack; the block SHALL then set storeTimeoutErr, drop storeReq and return to IDLE.
REQ-029 Kill: accept with killIn=1 SHALL enter HALTED and set haltOut; HALTED SHALL exit only on reset.
REQ-030 Kill combined with a store SHALL complete the store first, then enter HALTED.
REQ-031 retiredCount SHALL increment once per accepted instruction at accept+1 and wrap from 2^64-1 to 0.

Reset
REQ-032 Reset SHALL put the FSM in IDLE and clear every output and counter to 0, including the sticky flags.
REQ-033 Reset asserted in STORE_WAIT SHALL abandon the store; no storeReq SHALL appear after reset deasserts.

Configuration
REQ-034 Macro WB_FORWARD_EN defined: outputs fwdValid(1), fwdReg(4) and fwdData(64) SHALL mirror port A combinationally for decode bypass; undefined: these outputs SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-035 Package wb_pkg SHALL hold the FSM state enum, REG_W=4, DATA_W=64 and the default MAX_WAIT.
REQ-036 A sub-module wb_store_ctrl SHALL own STORE_WAIT, the request hold and the timeout counter.

Verification
REQ-037 Add retire: aluResultIn=0x5, destRegIn=3 valid, accept -> regWrEn=1, regWrAddr=3, regWrData=0x5 next cycle; retiredCount=1.
REQ-038 MUL retire: ports A=0 / B=2, results 0x10 / 0x1 -> both ports write in the same cycle; same address -> only A writes.
REQ-039 Store to address 0x1000, data 0xAB, ack delayed 3 cycles -> storeReq held 3 cycles with stable address/data, wbStallOut high throughout, IDLE after ack.
REQ-040 Store with ack never asserted, MAX_WAIT=4 -> storeTimeoutErr=1 after 4 waiting cycles; stall clears.
REQ-041 killIn with exValidIn -> haltOut=1 held; later exValidIn pulses produce no writes; reset clears haltOut.
REQ-042 retiredCount preloaded 0xFFFF_FFFF_FFFF_FFFF via force, one retire -> retiredCount=0.
